// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with a 2-flop synchronized line, mid-bit sampling.
// Latency: word, parity and framing status appear one cycle after the mid-stop sample.
// Backpressure: none; rx_data_valid is a single-cycle pulse the consumer must take.
module uart_rx #(
    parameter int BAUD_RATE   = 115200,
    parameter int CLK_RATE    = 100000000,
    parameter int WORD_WIDTH  = 8,
    parameter int EVEN_PARITY = 0
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  rx_data_in,
    output logic [WORD_WIDTH-1:0] rx_data_out,
    output logic                  rx_data_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_busy
);
    localparam int BIT_CNT  = CLK_RATE / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT + 1);
    localparam int IDX_W    = $clog2(WORD_WIDTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, next_state;
    logic                    sync0, rx_s, rx_prev;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [WORD_WIDTH-1:0]   shift;
    logic                    parity_bit;
    logic                    cnt_clr, shift_en, par_en, done;
    logic                    exp_parity;

    assign rx_busy    = (state != IDLE);
    assign exp_parity = (EVEN_PARITY != 0) ? (^shift) : (~^shift);

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        done       = 1'b0;
        case (state)
            // Requiring a real 1->0 transition keeps a held break from re-triggering.
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_prev && !rx_s) next_state = START;
            end
            START: begin
                if (cnt == HALF_LAST) next_state = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (idx == IDX_LAST) next_state = PARITY;
                end
            end
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    par_en     = 1'b1;
                    next_state = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (next_state != state) cnt_clr = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sync0         <= 1'b1;
            rx_s          <= 1'b1;
            rx_prev       <= 1'b1;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            parity_bit    <= 1'b0;
            rx_data_out   <= '0;
            rx_data_valid <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            sync0   <= rx_data_in;
            rx_s    <= sync0;
            rx_prev <= rx_s;
            cnt     <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state == START) idx <= '0;
            if (shift_en) begin
                shift <= {rx_s, shift[WORD_WIDTH-1:1]};
                idx   <= idx + IDX_W'(1);
            end
            if (par_en) parity_bit <= rx_s;
            rx_data_valid <= done;
            if (done) begin
                rx_data_out   <= shift;
                rx_parity_err <= (parity_bit != exp_parity);
                rx_frame_err  <= !rx_s;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, 8 data bits, odd parity.
module tb_uart_rx;
    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       rx_data_in = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_data_valid, rx_parity_err, rx_frame_err, rx_busy;

    int errors = 0;
    int checks = 0;

    uart_rx #(
        .BAUD_RATE(100000),
        .CLK_RATE(1600000),
        .WORD_WIDTH(8),
        .EVEN_PARITY(0)
    ) dut (
        .clock(clock),
        .rst(rst),
        .rx_data_in(rx_data_in),
        .rx_data_out(rx_data_out),
        .rx_data_valid(rx_data_valid),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clock = ~clock;

    // Pulse recorder: captures every valid pulse and flags back-to-back valids.
    int         cyc = 0;
    int         pulse_cnt = 0;
    int         dbl = 0;
    logic       prev_vld = 1'b0;
    logic [7:0] pd [0:63];
    logic       pp [0:63];
    logic       pf [0:63];
    int         pc [0:63];

    always @(negedge clock) begin
        cyc++;
        if (rx_data_valid === 1'b1) begin
            if (pulse_cnt < 64) begin
                pd[pulse_cnt] = rx_data_out;
                pp[pulse_cnt] = rx_parity_err;
                pf[pulse_cnt] = rx_frame_err;
                pc[pulse_cnt] = cyc;
            end
            if (prev_vld) dbl++;
            pulse_cnt++;
        end
        prev_vld = (rx_data_valid === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_data_in = b;
        tick(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_data_in = 1'b1;
        tick(3);
        checks++; if (rx_data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", rx_data_out); end
        checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_data_valid); end
        checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", rx_parity_err); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_good_frame;
        int p0 = pulse_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(20);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL good_pulses: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (pd[p0] !== 8'hA5) begin errors++; $display("FAIL good_data: got %0h expected a5", pd[p0]); end
        checks++; if (pp[p0] !== 1'b0) begin errors++; $display("FAIL good_perr: got %b expected 0", pp[p0]); end
        checks++; if (pf[p0] !== 1'b0) begin errors++; $display("FAIL good_ferr: got %b expected 0", pf[p0]); end
    endtask

    task automatic test_parity_err;
        int p0 = pulse_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        tick(20);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL par_pulses: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (pd[p0] !== 8'hA5) begin errors++; $display("FAIL par_data: got %0h expected a5", pd[p0]); end
        checks++; if (pp[p0] !== 1'b1) begin errors++; $display("FAIL par_perr: got %b expected 1", pp[p0]); end
        checks++; if (pf[p0] !== 1'b0) begin errors++; $display("FAIL par_ferr: got %b expected 0", pf[p0]); end
    endtask

    task automatic test_break;
        int p0 = pulse_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        rx_data_in = 1'b0;
        tick(40);
        rx_data_in = 1'b1;
        tick(40);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL brk_pulses: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (pd[p0] !== 8'h3C) begin errors++; $display("FAIL brk_data: got %0h expected 3c", pd[p0]); end
        checks++; if (pf[p0] !== 1'b1) begin errors++; $display("FAIL brk_ferr: got %b expected 1", pf[p0]); end
        checks++; if (pp[p0] !== 1'b0) begin errors++; $display("FAIL brk_perr: got %b expected 0", pp[p0]); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL brk_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_glitch;
        int p0 = pulse_cnt;
        int busy_n = 0;
        rx_data_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (rx_busy === 1'b1) busy_n++;
        end
        rx_data_in = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick(1);
            if (rx_busy === 1'b1) busy_n++;
        end
        checks++; if (busy_n < 1 || busy_n > 12) begin errors++; $display("FAIL glitch_busy_cycles: got %0d expected 1..12", busy_n); end
        checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_cnt - p0); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
    endtask

    task automatic test_back_to_back;
        int p0 = pulse_cnt;
        int gap;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        tick(20);
        gap = pc[p0+1] - pc[p0];
        checks++; if (pulse_cnt - p0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulse_cnt - p0); end
        checks++; if (pd[p0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %0h expected 00", pd[p0]); end
        checks++; if (pd[p0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %0h expected ff", pd[p0+1]); end
        checks++; if ({pp[p0], pf[p0], pp[p0+1], pf[p0+1]} !== 4'b0000) begin errors++; $display("FAIL b2b_flags: got %b%b%b%b expected 0000", pp[p0], pf[p0], pp[p0+1], pf[p0+1]); end
        checks++; if (gap < 175 || gap > 177) begin errors++; $display("FAIL b2b_spacing: got %0d expected 176", gap); end
    endtask

    task automatic test_reset_mid;
        int p0 = pulse_cnt;
        // 0xF0: bit 4 onward, parity and stop are all 1, so the aborted tail cannot fake a start edge.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx_data_in = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", rx_busy); end
        checks++; if (rx_data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0h expected 0", rx_data_out); end
        tick(7);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        tick(20);
        checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL rstmid_nopulse: got %0d expected 0", pulse_cnt - p0); end
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(20);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (pd[p0] !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %0h expected 5a", pd[p0]); end
        checks++; if ({pp[p0], pf[p0]} !== 2'b00) begin errors++; $display("FAIL rstmid_next_flags: got %b%b expected 00", pp[p0], pf[p0]); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_parity_err;
        test_break;
        test_glitch;
        test_back_to_back;
        test_reset_mid;
        checks++; if (dbl != 0) begin errors++; $display("FAIL valid_double: got %0d expected 0", dbl); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
